// File: rtl/mulpop_job_sequencer.sv
// rtl/mulpop_job_sequencer.sv - job-queue bus master for the gpioemu multiply/popcount peripheral (option macro: MULPOP_ONES_READ_EN)
module mulpop_job_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a,
  input  logic [23:0] job_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_product,
  output logic [23:0] res_ones,
  output logic        res_timeout,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        busy,
  output logic [15:0] job_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL, S_RD_RES, S_RD_ONES, S_OUT
  } state_t;

  state_t      state, state_d;
  logic [1:0]  phase;
  logic [7:0]  poll_cnt;
  logic [23:0] a_q, b_q;
  logic [47:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic        in_access, hold_end, strobe, poll_done, poll_last;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pop       = (state == S_IDLE) && !empty && !res_valid;
  assign busy      = (state != S_IDLE);
  assign in_access = (state != S_IDLE) && (state != S_OUT);
  assign hold_end  = (phase == 2'd2);
  // Strobes are gated by reset so they fall the instant reset rises.
  assign strobe    = (phase == 2'd1) && !reset;
  assign poll_done = (sdata_in[1:0] == 2'b11);
  assign poll_last = (poll_cnt == 8'(POLL_LIMIT - 1));

  // Job queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {job_a, job_b};
  end

  // Queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state and bus drive; each access is SETUP, STROBE, HOLD (phase 0,1,2).
  always_comb begin
    state_d   = state;
    saddress  = '0;
    sdata_out = '0;
    swr       = 1'b0;
    srd       = 1'b0;
    case (state)
      S_IDLE: if (pop) state_d = S_WR_A;
      S_WR_A: begin
        saddress  = 16'h037F;
        sdata_out = {8'h0, a_q};
        swr       = strobe;
        if (hold_end) state_d = S_WR_B;
      end
      S_WR_B: begin
        saddress  = 16'h0388;
        sdata_out = {8'h0, b_q};
        swr       = strobe;
        if (hold_end) state_d = S_WR_GO;
      end
      S_WR_GO: begin
        saddress = 16'h03A0;
        swr      = strobe;
        if (hold_end) state_d = S_POLL;
      end
      S_POLL: begin
        saddress = 16'h03A0;
        srd      = strobe;
        if (hold_end) begin
          if (poll_done)      state_d = S_RD_RES;
          else if (poll_last) state_d = S_OUT;
        end
      end
      S_RD_RES: begin
        saddress = 16'h0390;
        srd      = strobe;
`ifdef MULPOP_ONES_READ_EN
        if (hold_end) state_d = S_RD_ONES;
`else
        if (hold_end) state_d = S_OUT;
`endif
      end
      S_RD_ONES: begin
`ifdef MULPOP_ONES_READ_EN
        saddress = 16'h0398;
        srd      = strobe;
        if (hold_end) state_d = S_OUT;
`else
        state_d = S_OUT;
`endif
      end
      S_OUT: if (res_valid && res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MULPOP_ONES_READ_EN
  logic [23:0] ones_q;
  assign res_ones = ones_q;
`else
  logic [5:0] ones_cnt;
  // Local popcount of the held product; a timed-out job has product 0, hence ones 0.
  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < 32; i++) ones_cnt = ones_cnt + {5'b0, res_product[i]};
  end
  assign res_ones = {18'b0, ones_cnt};
`endif

  // Datapath: operand latch, access phase, poll counting, result capture and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      phase       <= '0;
      poll_cnt    <= '0;
      res_product <= '0;
      res_timeout <= 1'b0;
      res_valid   <= 1'b0;
      job_count   <= '0;
`ifdef MULPOP_ONES_READ_EN
      ones_q      <= '0;
`endif
    end else begin
      if (pop) begin
        {a_q, b_q}  <= fifo_mem[rd_ptr[AW-1:0]];
        poll_cnt    <= '0;
        res_product <= '0;
        res_timeout <= 1'b0;
`ifdef MULPOP_ONES_READ_EN
        ones_q      <= '0;
`endif
      end
      if (in_access) phase <= hold_end ? 2'd0 : phase + 2'd1;
      else           phase <= 2'd0;
      if (state == S_POLL && hold_end && !poll_done) begin
        poll_cnt <= poll_cnt + 8'd1;
        if (poll_last) res_timeout <= 1'b1;
      end
      if (state == S_RD_RES && hold_end) res_product <= sdata_in;
`ifdef MULPOP_ONES_READ_EN
      if (state == S_RD_ONES && hold_end) ones_q <= sdata_in[23:0];
`endif
      if (state == S_OUT) begin
        if (!res_valid) begin
          res_valid <= 1'b1;
        end else if (res_ready) begin
          res_valid <= 1'b0;
          job_count <= job_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mulpop_job_sequencer.sv
// tb/tb_mulpop_job_sequencer.sv - scoreboard bench for mulpop_job_sequencer with gpioemu bus model
module tb_mulpop_job_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid = 1'b0, job_ready;
  logic [23:0] job_a = '0, job_b = '0;
  logic        res_valid, res_ready = 1'b1;
  logic [31:0] res_product;
  logic [23:0] res_ones;
  logic        res_timeout;
  logic [15:0] saddress;
  logic        swr, srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in = '0;
  logic        busy;
  logic [15:0] job_count;

  int checks = 0;
  int failures = 0;

  typedef struct {logic [31:0] p; logic [23:0] o; logic t;} exp_t;
  typedef struct {logic wr; logic [15:0] addr; logic [31:0] data;} bus_t;
  exp_t exp_q[$];
  bus_t trace[$];

  // Peripheral model state
  logic [23:0] per_a = '0, per_b = '0;
  logic [47:0] per_full = '0;
  int          stat_reads = 0;
  int          done_after = 2;
  bit          both_seen = 0;
  bit          watch_valid = 0;
  bit          valid_seen = 0;

  always #5 clk = ~clk;

  mulpop_job_sequencer #(.FIFO_DEPTH(4), .POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_ones(res_ones), .res_timeout(res_timeout),
    .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in),
    .busy(busy), .job_count(job_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // gpioemu model: writes latch operands, GO starts a new status sequence
  always @(posedge swr) begin
    trace.push_back('{1'b1, saddress, sdata_out});
    case (saddress)
      16'h037F: per_a = sdata_out[23:0];
      16'h0388: per_b = sdata_out[23:0];
      16'h03A0: begin
        stat_reads = 0;
        per_full   = {24'b0, per_a} * {24'b0, per_b};
      end
      default: ;
    endcase
  end

  always @(posedge srd) begin
    trace.push_back('{1'b0, saddress, 32'h0});
    case (saddress)
      16'h03A0: begin
        stat_reads++;
        sdata_in = (stat_reads >= done_after) ? 32'h3 : 32'h1;
      end
      16'h0390: sdata_in = per_full[31:0];
      16'h0398: sdata_in = {8'h0, 18'h0, 6'($countones(per_full[31:0]))};
      default:  sdata_in = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk or negedge clk) if (swr && srd) both_seen = 1;

  always @(negedge clk) if (watch_valid && res_valid) valid_seen = 1;

  // Result monitor: compares each handshaken result against the scoreboard head
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_product", res_product, e.p);
        chk("res_ones", res_ones, e.o);
        chk("res_timeout", res_timeout, e.t);
      end
    end
  end

  task automatic push_job(input logic [23:0] a, input logic [23:0] b,
                          input logic [31:0] p, input logic [23:0] o, input logic t);
    int n;
    n = 0;
    @(negedge clk);
    job_valid = 1; job_a = a; job_b = b;
    while (!job_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_accept", job_ready, 1);
    exp_q.push_back('{p, o, t});
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic push_try(input logic [23:0] a, input logic [23:0] b,
                          input logic [31:0] p, input logic [23:0] o, output bit acc);
    @(negedge clk);
    job_valid = 1; job_a = a; job_b = b;
    acc = job_ready;
    if (acc) exp_q.push_back('{p, o, 1'b0});
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || res_valid) && n < max) begin @(negedge clk); n++; end
    chk("drain_in_time", (n < max), 1);
  endtask

  task automatic count_reads(input logic [15:0] addr, output int cnt);
    cnt = 0;
    foreach (trace[i]) if (!trace[i].wr && trace[i].addr == addr) cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, n, nread, acc_cnt;
    bit  acc;
    bus_t exp_tr[$];

    // Reset state
    reset = 1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_saddress", saddress, 0);
    chk("rst_swr", swr, 0);
    chk("rst_srd", srd, 0);
    chk("rst_sdata_out", sdata_out, 0);
    chk("rst_product", res_product, 0);
    chk("rst_timeout", res_timeout, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // Job 3*5, done on second poll: latency and bus trace
    done_after = 2;
    res_ready  = 1;
    trace.delete();
    push_job(24'd3, 24'd5, 32'd15, 24'd4, 1'b0);
    lat = 0;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
`ifdef MULPOP_ONES_READ_EN
    chk("latency_pop_to_valid", lat, 23);
`else
    chk("latency_pop_to_valid", lat, 20);
`endif
    wait_idle(200);
    exp_tr.push_back('{1'b1, 16'h037F, 32'd3});
    exp_tr.push_back('{1'b1, 16'h0388, 32'd5});
    exp_tr.push_back('{1'b1, 16'h03A0, 32'd0});
    exp_tr.push_back('{1'b0, 16'h03A0, 32'd0});
    exp_tr.push_back('{1'b0, 16'h03A0, 32'd0});
    exp_tr.push_back('{1'b0, 16'h0390, 32'd0});
`ifdef MULPOP_ONES_READ_EN
    exp_tr.push_back('{1'b0, 16'h0398, 32'd0});
`endif
    chk("trace_len", trace.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
      chk($sformatf("trace_%0d", i), {trace[i].wr, trace[i].addr, trace[i].data},
          {exp_tr[i].wr, exp_tr[i].addr, exp_tr[i].data});

    // Largest operands
    push_job(24'hFFFFFF, 24'hFFFFFF, 32'hFE000001, 24'd8, 1'b0);
    wait_idle(200);

    // Status stuck at 2'b01: timeout after exactly POLL_LIMIT=4 reads
    done_after = 1000;
    trace.delete();
    push_job(24'd7, 24'd9, 32'd0, 24'd0, 1'b1);
    wait_idle(200);
    count_reads(16'h03A0, nread);
    chk("timeout_status_reads", nread, 4);
    count_reads(16'h0390, nread);
    chk("timeout_no_result_read", nread, 0);
    chk("job_count_after_3", job_count, 3);

    // Backpressure: 6 pushes with res_ready low, depth 4
    reset = 1; exp_q.delete();
    @(negedge clk); reset = 0;
    chk("job_count_after_reset", job_count, 0);
    done_after = 1;
    res_ready  = 0;
    acc_cnt = 0;
    push_try(24'd2,   24'd3,     32'd6,      24'd2,  acc); acc_cnt += acc;
    push_try(24'd4,   24'd4,     32'd16,     24'd1,  acc); acc_cnt += acc;
    push_try(24'h10,  24'h10,    32'h100,    24'd1,  acc); acc_cnt += acc;
    push_try(24'd7,   24'd7,     32'd49,     24'd3,  acc); acc_cnt += acc;
    push_try(24'hFF,  24'h101,   32'hFFFF,   24'd16, acc); acc_cnt += acc;
    push_try(24'd1,   24'd1,     32'd1,      24'd1,  acc); acc_cnt += acc;
    chk("bp_accepted", acc_cnt, 5);
    chk("bp_job_ready_full", job_ready, 0);
    repeat (40) @(negedge clk);
    chk("bp_result_held", res_valid, 1);
    chk("bp_product_held", res_product, 32'd6);
    res_ready = 1;
    wait_idle(1000);
    chk("bp_job_count", job_count, 5);

    // Reset during POLL with a second job queued
    done_after = 1000;
    push_job(24'd11, 24'd13, 32'd0, 24'd0, 1'b1);
    push_job(24'd5,  24'd6,  32'd0, 24'd0, 1'b1);
    n = 0;
    while (!(srd && saddress == 16'h03A0) && n < 200) begin @(posedge clk); #1; n++; end
    chk("reached_poll", (n < 200), 1);
    #2 reset = 1;
    exp_q.delete();
    #1;
    chk("mid_rst_srd", srd, 0);
    chk("mid_rst_swr", swr, 0);
    chk("mid_rst_job_ready", job_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_job_count", job_count, 0);
    @(negedge clk);
    reset = 0;
    watch_valid = 1;
    repeat (60) @(negedge clk);
    chk("post_rst_no_valid", valid_seen, 0);
    chk("post_rst_fifo_empty_idle", busy, 0);
    chk("post_rst_job_count", job_count, 0);
    chk("never_both_strobes", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
